// File: rtl/demux_dispatch_ctrl.sv
// 1-to-4 demux dispatch controller: valid/ready input steered into a
// one-beat output register, round-robin or direct target, delivery count.
module demux_dispatch_ctrl #(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic [1:0]    sel,
    input  logic [3:0]    en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic [3:0]    out_valid,
    output logic [DW-1:0] out_data,
    input  logic [3:0]    out_ready,
    output logic [CW-1:0] dlv_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [1:0]      r_g;
    logic [1:0]      r_rr;
    logic [DW-1:0]   r_data;
    logic [CW-1:0]   r_cnt;

    logic [1:0]      w_idx;
    logic [1:0]      w_rr_tgt;
    logic [1:0]      w_tgt;
    logic            w_elig;
    logic [3:0]      w_out_valid;
    logic            w_out_fire;
    logic            w_in_fire;

    // Scan from far to near so the nearest enabled channel after r_rr wins.
    always_comb begin
        w_idx    = 2'd0;
        w_rr_tgt = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_rr + 2'(k);
            if (en[w_idx]) begin
                w_rr_tgt = w_idx;
            end
        end
    end

    always_comb begin
        if (mode) begin
            w_tgt  = sel;
            w_elig = en[sel];
        end else begin
            w_tgt  = w_rr_tgt;
            w_elig = |en;
        end
    end

    assign w_out_valid = (r_state == HOLD) ? (4'b0001 << r_g) : 4'b0000;
    assign w_out_fire  = |(w_out_valid & out_ready);
    assign in_ready    = w_elig & ((r_state == IDLE) | w_out_fire);
    assign w_in_fire   = in_valid & in_ready;

    always_comb begin
        w_state_nx = r_state;
        if (w_in_fire) begin
            w_state_nx = HOLD;
        end else if (w_out_fire) begin
            w_state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g    <= 2'd0;
            r_rr   <= 2'd3;
            r_data <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_in_fire) begin
                r_g    <= w_tgt;
                r_data <= in_data;
                if (!mode) begin
                    r_rr <= w_tgt;
                end
            end
            if (w_out_fire) begin
                r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = w_out_valid;
    assign out_data  = r_data;
    assign dlv_cnt   = r_cnt;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model.
module tb_demux_dispatch_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic [3:0]    en = 4'h0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic [3:0]    out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    out_ready = 4'h0;
    logic [CW-1:0] dlv_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: held beat (valid/channel/data), rr pointer, delivery count.
    bit       m_valid;
    int       m_ch;
    int       m_data;
    int       m_rr;
    int       m_cnt;
    bit       n_valid;
    int       n_ch;
    int       n_data;
    int       n_rr;
    int       n_cnt;

    demux_dispatch_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .en        (en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .dlv_cnt   (dlv_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_valid = 0;
        m_ch    = 0;
        m_data  = 0;
        m_rr    = 3;
        m_cnt   = 0;
    endtask

    // One clock: check outputs at negedge, predict, commit after posedge.
    task automatic cycle();
        int  tgt;
        bit  elig;
        bit  ofire;
        bit  ifire;
        bit  rdy;
        @(negedge clk);
        if (mode) begin
            tgt  = int'(sel);
            elig = en[sel];
        end else begin
            tgt  = 0;
            elig = (en != 4'h0);
            for (int k = 4; k >= 1; k--) begin
                if (en[(m_rr + k) % 4]) tgt = (m_rr + k) % 4;
            end
        end
        ofire = m_valid && out_ready[m_ch];
        rdy   = elig && (!m_valid || ofire);
        ifire = in_valid && rdy;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("out_valid", 32'(out_valid),
            m_valid ? (32'd1 << m_ch) : 32'd0);
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("dlv_cnt", 32'(dlv_cnt), 32'(m_cnt));
        n_valid = m_valid;
        n_ch    = m_ch;
        n_data  = m_data;
        n_rr    = m_rr;
        n_cnt   = ofire ? (m_cnt + 1) % (1 << CW) : m_cnt;
        if (ifire) begin
            n_valid = 1;
            n_ch    = tgt;
            n_data  = int'(in_data);
            if (!mode) n_rr = tgt;
        end else if (ofire) begin
            n_valid = 0;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid;
        m_ch    = n_ch;
        m_data  = n_data;
        m_rr    = n_rr;
        m_cnt   = n_cnt;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_cnt", 32'(dlv_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        #2;
        do_reset();
        chk("rst_od", 32'(out_data), 32'd0);

        // T1: round-robin over all four, back-to-back
        mode = 0; en = 4'hF; out_ready = 4'hF;
        in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            in_data = 8'(8'h10 + i);
            cycle();
            chk("t1_ov", 32'(out_valid), 32'd1 << (i % 4));
            chk("t1_od", 32'(out_data), 32'(8'h10 + i));
        end
        in_valid = 0;
        cycle();
        chk("t1_cnt", 32'(dlv_cnt), 32'd8);

        // T2: only ch1 and ch3 enabled
        en = 4'b1010; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'h20 + i);
            cycle();
            chk("t2_ov", 32'(out_valid), (i % 2 == 0) ? 32'h2 : 32'h8);
        end
        in_valid = 0;
        cycle();

        // T3: direct select ch2, consumer stalls for 5 cycles
        mode = 1; sel = 2; en = 4'hF; out_ready = 4'b1011;
        in_valid = 1; in_data = 8'hA5;
        cycle();
        in_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            chk("t3_ov", 32'(out_valid), 32'h4);
            chk("t3_od", 32'(out_data), 32'hA5);
            chk("t3_rdy", 32'(in_ready), 32'd0);
            cycle();
        end
        in_valid = 0; out_ready = 4'hF;
        cycle();
        chk("t3_cnt", 32'(dlv_cnt), 32'd13);
        cycle();

        // T4: held beat for ch0 drains after en drops to zero
        mode = 1; sel = 0; en = 4'hF; out_ready = 4'h0;
        in_valid = 1; in_data = 8'h3C;
        cycle();
        en = 4'h0;
        cycle();
        chk("t4_rdy", 32'(in_ready), 32'd0);
        chk("t4_ov", 32'(out_valid), 32'h1);
        out_ready = 4'h1;
        cycle();
        chk("t4_idle", 32'(out_valid), 32'd0);
        in_valid = 0;
        cycle();

        // T5: direct select to a disabled channel never accepts
        mode = 1; sel = 1; en = 4'b1101; in_valid = 1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t5_rdy", 32'(in_ready), 32'd0);
            chk("t5_ov", 32'(out_valid), 32'd0);
        end
        in_valid = 0;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 3) == 0);
            sel       = 2'($urandom);
            en        = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            in_valid  = 1'($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            cycle();
        end
        in_valid = 0; out_ready = 4'hF;
        cycle();
        cycle();

        // T6: counter wrap, then reset mid-HOLD
        do_reset();
        mode = 0; en = 4'hF; out_ready = 4'hF; in_valid = 1;
        for (int i = 0; i < 17; i++) begin
            in_data = 8'($urandom);
            cycle();
        end
        in_valid = 0;
        cycle();
        chk("t6_wrap", 32'(dlv_cnt), 32'd1);
        out_ready = 4'h0; in_valid = 1; in_data = 8'h77;
        cycle();
        in_valid = 0;
        chk("t6_hold", 32'(out_valid), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async", 32'(out_valid), 32'd0);
        chk("t6_cnt0", 32'(dlv_cnt), 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 4'hF; in_valid = 1; in_data = 8'h99;
        cycle();
        chk("t6_rr0", 32'(out_valid), 32'h1);
        in_valid = 0;
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
